uart_tx_frame: RTL
==================

// Module: uart_tx_frame
// PURPOSE
// - UART transmitter. Serialises one parallel byte into a frame: start, data LSB-first, optional parity, stop.
// - Bit time is `prescale` clk cycles, using the same per-link prescale value the receive side samples with.
// - Sits between the TX async FIFO read side and the tx_out pad.
// - Internal edge counter: timebase that holds each bit for `prescale` clocks.
// PARAMETERS
// - DATA_WIDTH      8  payload bits per frame
// - PRESCALE_WIDTH  6  width of prescale and of the internal edge counter
// PORTS
// - clk         in   1               system clock; all logic on posedge
// - rst         in   1               asynchronous, active-low reset
// - p_data      in   DATA_WIDTH      byte to send; sampled on acceptance
// - data_valid  in   1               request; accepted when high and busy low
// - par_en      in   1               1 = parity bit present; sampled on acceptance
// - par_typ     in   1               0 = even, 1 = odd; sampled on acceptance
// - prescale    in   PRESCALE_WIDTH  clk cycles per bit; sampled on acceptance
// - tx_out      out  1               serial line, registered, idles high
// - busy        out  1               registered; high while a frame is on the line
// BEHAVIOUR
// - Reset: state=IDLE, tx_out=1, busy=0, edge_cnt=0, bit_cnt=0.
// - Reset is asynchronous: a mid-frame assertion aborts the frame at once (tx_out=1, busy=0); the partial frame is lost.
// - FSM states and transitions:
//   - IDLE -> START: on data_valid && !busy. Latch p_data, par_en, par_typ, prescale.
//   - START: tx_out=0.
//   - DATA: tx_out=data[bit_cnt], bit_cnt 0..DATA_WIDTH-1.
//   - PARITY: entered only if par_en. Even: tx_out = ^data. Odd: tx_out = ~^data.
//   - STOP: tx_out=1. Then back to IDLE.
// - Cycle timing:
//   - Start bit and busy=1 appear on the cycle after acceptance.
//   - Each bit holds exactly P clocks. Advance when edge_cnt==P-1; edge_cnt then returns to 0.
//   - P = latched prescale. prescale=0 wraps to 2^PRESCALE_WIDTH (64) clocks per bit.
//   - busy is high for exactly N*P cycles, N = 1+DATA_WIDTH+par_en+stop_bits.
// - Back-to-back: busy falls on the cycle state returns to IDLE. A request held high is accepted on that cycle.
//   - Result: at least 1 idle-high clock between frames.
// - Input changes while busy (p_data, par_*, prescale) have no effect on the current frame.
// - data_valid while busy is ignored, not queued. The requester holds it until it sees busy low.
// - tx_out is driven only from the state/data registers, so it is glitch-free.
// CONFIGURATION
// - Macro UART_TX_STOP2_EN.
//   - Defined: adds input port stop2 (1 bit), sampled on acceptance.
//   - stop2=1 -> STOP lasts 2*P clocks (two stop bits); stop_bits=2 in the N formula.
//   - Not defined: no stop2 port; always one stop bit, and the logic is absent.
// STRUCTURE
// - Package uart_pkg:
//   - FSM state encoding (IDLE, START, DATA, PARITY, STOP).
//   - PAR_EVEN=1'b0, PAR_ODD=1'b1.
//   - Shared with the receive path.
// - Sub-module uart_tx_bit_timer:
//   - Edge counter that loads prescale and pulses bit_done at edge_cnt==P-1.
//   - Clears on a start input.
// - Top level holds the FSM, data/parity registers, bit_cnt and the output register.
// TESTING
// - Frame 0xA5, par_en=1, par_typ=0, prescale=8:
//   - tx_out = 0,1,0,1,0,0,1,0,1,0,1, each bit 8 clks.
//   - busy high 88 clks.
// - Frame 0x01, par_en=1, par_typ=1, prescale=4:
//   - Parity bit = 0. Frame 11 bits, busy 44 clks.
// - par_en=0, prescale=0:
//   - 10-bit frame, 64 clks per bit, busy 640 clks.
// - data_valid held high for 3 frames of 0x3C, prescale=2:
//   - Each frame's busy falls for exactly 1 clk, then the next start bit appears.
//   - No lost or duplicated frame.
// - Reset pulse mid-frame, at data bit 3:
//   - tx_out=1 and busy=0 within the reset cycle.
//   - After release, a new 0x55 frame is sent cleanly.
// - Change p_data/prescale mid-frame, and (UART_TX_STOP2_EN) stop2=1 with prescale=5:
//   - Frame is unchanged by the mid-frame inputs.
//   - Stop bit high for 10 clks.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity polarity and parity helper.
// Used by both the transmit and receive paths.
package uart_pkg;

    localparam int unsigned STATE_WIDTH = 3;

    localparam logic [STATE_WIDTH-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_WIDTH-1:0] ST_START  = 3'd1;
    localparam logic [STATE_WIDTH-1:0] ST_DATA   = 3'd2;
    localparam logic [STATE_WIDTH-1:0] ST_PARITY = 3'd3;
    localparam logic [STATE_WIDTH-1:0] ST_STOP   = 3'd4;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // data_xor is the XOR reduction of the payload
    function automatic logic parity_bit(input logic data_xor, input logic par_typ);
        return (par_typ == PAR_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit timebase: counts clk edges and pulses bit_done_c on the last clock of each bit.
// prescale=0 wraps to 2^PRESCALE_WIDTH clocks per bit.
module uart_tx_bit_timer #(
    parameter int unsigned PRESCALE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      en,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      bit_done_c
);

    logic [PRESCALE_WIDTH-1:0] edge_cnt;
    logic [PRESCALE_WIDTH-1:0] last_cnt_c;

    assign last_cnt_c = prescale - PRESCALE_WIDTH'(1);
    assign bit_done_c = en && (edge_cnt == last_cnt_c);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_cnt <= '0;
        end else if (start) begin
            edge_cnt <= '0;
        end else if (en) begin
            edge_cnt <= bit_done_c ? '0 : edge_cnt + PRESCALE_WIDTH'(1);
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, DATA_WIDTH bits LSB-first, optional parity, stop bit(s).
// Optional feature macro: UART_TX_STOP2_EN adds the stop2 input (two stop bits).
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned PRESCALE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     p_data,
    input  logic                      data_valid,
    input  logic                      par_en,
    input  logic                      par_typ,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
`ifdef UART_TX_STOP2_EN
    input  logic                      stop2,
`endif
    output logic                      tx_out,
    output logic                      busy
);

    localparam int unsigned BIT_CNT_WIDTH = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_CNT_WIDTH-1:0] LAST_BIT = BIT_CNT_WIDTH'(DATA_WIDTH - 1);

    logic [STATE_WIDTH-1:0]    state, state_d;
    logic [BIT_CNT_WIDTH-1:0]  bit_cnt, bit_cnt_d;
    logic                      tx_d, busy_d;
    logic [DATA_WIDTH-1:0]     data_q;
    logic                      par_en_q, par_typ_q;
    logic [PRESCALE_WIDTH-1:0] prescale_q;
    logic                      accept_c, bit_done_c, last_stop_c;

    assign accept_c = data_valid && !busy;

`ifdef UART_TX_STOP2_EN
    logic stop2_q;
    assign last_stop_c = !stop2_q || (bit_cnt != '0);
`else
    assign last_stop_c = 1'b1;
`endif

    uart_tx_bit_timer #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_bit_timer (
        .clk       (clk),
        .rst       (rst),
        .start     (accept_c),
        .en        (busy),
        .prescale  (prescale_q),
        .bit_done_c(bit_done_c)
    );

    // Frame configuration is frozen at acceptance
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= PAR_EVEN;
            prescale_q <= '0;
`ifdef UART_TX_STOP2_EN
            stop2_q    <= 1'b0;
`endif
        end else if (accept_c) begin
            data_q     <= p_data;
            par_en_q   <= par_en;
            par_typ_q  <= par_typ;
            prescale_q <= prescale;
`ifdef UART_TX_STOP2_EN
            stop2_q    <= stop2;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            tx_out  <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state   <= state_d;
            bit_cnt <= bit_cnt_d;
            tx_out  <= tx_d;
            busy    <= busy_d;
        end
    end

    // Next state plus the next values of the registered line outputs
    always_comb begin
        state_d   = state;
        bit_cnt_d = bit_cnt;
        tx_d      = tx_out;
        busy_d    = busy;
        case (state)
            ST_IDLE: begin
                if (accept_c) begin
                    state_d   = ST_START;
                    bit_cnt_d = '0;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            ST_START: begin
                if (bit_done_c) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                    tx_d      = data_q[0];
                end
            end
            ST_DATA: begin
                if (bit_done_c) begin
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_d = '0;
                        if (par_en_q) begin
                            state_d = ST_PARITY;
                            tx_d    = parity_bit(^data_q, par_typ_q);
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt + BIT_CNT_WIDTH'(1);
                        tx_d      = data_q[bit_cnt_d];
                    end
                end
            end
            ST_PARITY: begin
                if (bit_done_c) begin
                    state_d   = ST_STOP;
                    bit_cnt_d = '0;
                    tx_d      = 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_done_c) begin
                    if (last_stop_c) begin
                        state_d   = ST_IDLE;
                        bit_cnt_d = '0;
                        busy_d    = 1'b0;
                    end else begin
                        bit_cnt_d = BIT_CNT_WIDTH'(1);
                    end
                    tx_d = 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
                tx_d      = 1'b1;
                busy_d    = 1'b0;
            end
        endcase
    end

endmodule
